load_store_unit: RTL

//   Sits directly upstream of the 64x32 word data memory and drives its port.

---
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// CPU-side Req/Busy/Done handshake and word-memory port of the load/store unit.
// master = CPU plus data memory, slave = load_store_unit.
interface load_store_unit_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned WADDR_W = ADDR_W - 2;

   logic                 Req;
   logic                 Load;
   logic                 Store;
   logic [1:0]           Size;
   logic                 Unsigned;
   logic [ADDR_W-1:0]    ByteAddr;
   logic [DATA_W-1:0]    StoreData;
   logic                 Busy;
   logic                 Done;
   logic [DATA_W-1:0]    LoadData;
   logic                 AddrError;
   logic [WADDR_W-1:0]   MemAddress;
   logic [DATA_W-1:0]    MemWriteData;
   logic                 MemRead;
   logic                 MemWrite;
   logic [DATA_W-1:0]    MemReadData;

   modport master (
      output Req, Load, Store, Size, Unsigned, ByteAddr, StoreData, MemReadData,
      input  Busy, Done, LoadData, AddrError, MemAddress, MemWriteData, MemRead, MemWrite
   );

   modport slave (
      input  Req, Load, Store, Size, Unsigned, ByteAddr, StoreData, MemReadData,
      output Busy, Done, LoadData, AddrError, MemAddress, MemWriteData, MemRead, MemWrite
   );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a 64x32 word memory; sub-word stores use read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses skip memory and report AddrError.
module load_store_unit #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input  logic          Clock,
   input  logic          Reset,
   load_store_unit_if.slave bus
);
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;

   typedef enum logic [2:0] {IDLE, RD, LCAP, MERGE, WR, RESP} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   addr_q;
   logic [1:0]          size_q;
   logic                uns_q;
   logic                is_load_q;
   logic [DATA_W-1:0]   sdata_q;
   logic                busy_q;
   logic                done_q;
   logic                mem_read_q;
   logic                mem_write_q;
   logic [DATA_W-1:0]   load_data_q;

   logic [4:0]          shift;
   logic [DATA_W-1:0]   mask;
   logic [DATA_W-1:0]   ins;
   logic [DATA_W-1:0]   merged;
   logic [DATA_W-1:0]   load_ext;
   logic [7:0]          rd_byte;
   logic [15:0]         rd_half;

`ifdef MISALIGN_TRAP_EN
   logic                err_q;
   logic                misalign_c;

   assign misalign_c = ((bus.Size == SIZE_HALF) && bus.ByteAddr[0]) ||
                       (bus.Size[1] && (bus.ByteAddr[1:0] != 2'b00));
   assign bus.AddrError = err_q;
`else
   assign bus.AddrError = 1'b0;
`endif

   // Lane select for load extension and store merge; half uses addr[1], word ignores low bits
   always_comb begin
      shift    = '0;
      mask     = '0;
      ins      = '0;
      rd_byte  = '0;
      rd_half  = '0;
      load_ext = bus.MemReadData;
      case (size_q)
         SIZE_BYTE: begin
            shift    = {addr_q[1:0], 3'b000};
            rd_byte  = 8'(bus.MemReadData >> shift);
            load_ext = {{(DATA_W-8){~uns_q & rd_byte[7]}}, rd_byte};
            mask     = DATA_W'(8'hFF) << shift;
            ins      = DATA_W'(sdata_q[7:0]) << shift;
         end
         SIZE_HALF: begin
            shift    = {addr_q[1], 4'b0000};
            rd_half  = 16'(bus.MemReadData >> shift);
            load_ext = {{(DATA_W-16){~uns_q & rd_half[15]}}, rd_half};
            mask     = DATA_W'(16'hFFFF) << shift;
            ins      = DATA_W'(sdata_q[15:0]) << shift;
         end
         default: ;
      endcase
      merged = (bus.MemReadData & ~mask) | (ins & mask);
   end

   assign bus.Busy         = busy_q;
   assign bus.Done         = done_q;
   assign bus.LoadData     = load_data_q;
   assign bus.MemAddress   = addr_q[ADDR_W-1:2];
   assign bus.MemWriteData = (state == MERGE) ? merged : sdata_q;
   // Reset gates the strobes so no memory access can occur in a reset cycle
   assign bus.MemRead      = mem_read_q & ~Reset;
   assign bus.MemWrite     = mem_write_q & ~Reset;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= IDLE;
         addr_q      <= '0;
         size_q      <= '0;
         uns_q       <= 1'b0;
         is_load_q   <= 1'b0;
         sdata_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         load_data_q <= '0;
`ifdef MISALIGN_TRAP_EN
         err_q       <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.Req && (bus.Load != bus.Store)) begin
                  addr_q    <= bus.ByteAddr;
                  size_q    <= bus.Size;
                  uns_q     <= bus.Unsigned;
                  is_load_q <= bus.Load;
                  sdata_q   <= bus.StoreData;
                  busy_q    <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                  err_q     <= misalign_c;
                  if (misalign_c) begin
                     state  <= RESP;
                     done_q <= 1'b1;
                  end else
`endif
                  if (bus.Load || !bus.Size[1]) begin
                     state      <= RD;
                     mem_read_q <= 1'b1;
                  end else begin
                     state       <= WR;
                     mem_write_q <= 1'b1;
                  end
               end
            end
            RD: begin
               mem_read_q <= 1'b0;
               if (is_load_q) begin
                  state <= LCAP;
               end else begin
                  state       <= MERGE;
                  mem_write_q <= 1'b1;
               end
            end
            LCAP: begin
               load_data_q <= load_ext;
               state       <= RESP;
               done_q      <= 1'b1;
            end
            MERGE, WR: begin
               mem_write_q <= 1'b0;
               state       <= RESP;
               done_q      <= 1'b1;
            end
            RESP: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state       <= IDLE;
               busy_q      <= 1'b0;
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b0;
            end
         endcase
      end
   end
endmodule
